// File: rtl/pdm_deserializer.sv
// PDM deserializer: samples a 1-bit PDM mic line on generator rising-edge
// pulses, packs WORD_W samples MSB-first into words and streams them out
// through a 2-entry AXI4-Stream buffer with frame tlast and a sticky
// overflow flag for words dropped under back-pressure.
module pdm_deserializer #(
  parameter int WORD_W      = 16,
  parameter int FRAME_WORDS = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              m_clk_rising,
  input  logic              pdm_data,
  output logic [WORD_W-1:0] m_axis_tdata,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic              m_axis_tlast,
  output logic              overflow,
  input  logic              overflow_clr
);

  localparam int CNT_W = $clog2(WORD_W);
  localparam int FRM_W = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(WORD_W - 1);
  localparam logic [FRM_W-1:0] LAST_WORD = FRM_W'(FRAME_WORDS - 1);

  logic [1:0]        sync_q, sync_d;
  logic [WORD_W-2:0] shift_q, shift_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [FRM_W-1:0]  frame_q, frame_d;
  logic [WORD_W-1:0] data0_q, data0_d, data1_q, data1_d;
  logic              last0_q, last0_d, last1_q, last1_d;
  logic [1:0]        cnt_q, cnt_d;
  logic              ovf_q, ovf_d;

  logic              pdm_s, sample, push, pop, drop, accept, word_last;
  logic [WORD_W-1:0] word;

  assign pdm_s     = sync_q[1];
  assign sample    = en && m_clk_rising;
  assign word      = {shift_q, pdm_s};
  assign push      = sample && (bit_cnt_q == LAST_BIT);
  assign pop       = (cnt_q != 2'd0) && m_axis_tready;
  // A full buffer can still take a word if the head leaves on the same edge.
  assign drop      = push && (cnt_q == 2'd2) && !pop;
  assign accept    = push && !drop;
  assign word_last = (frame_q == LAST_WORD);

  // Next-state: synchronizer, packer, frame position, buffer and overflow.
  always_comb begin
    sync_d    = {sync_q[0], pdm_data};
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    frame_d   = frame_q;
    data0_d   = data0_q;
    data1_d   = data1_q;
    last0_d   = last0_q;
    last1_d   = last1_q;
    cnt_d     = cnt_q;

    // Idle clears the partial word and frame position; the buffer keeps draining.
    if (!en) begin
      shift_d   = '0;
      bit_cnt_d = '0;
      frame_d   = '0;
    end else if (sample) begin
      shift_d   = word[WORD_W-2:0];
      bit_cnt_d = push ? '0 : bit_cnt_q + 1'b1;
      // Dropped words do not consume a frame slot.
      if (accept) frame_d = word_last ? '0 : frame_q + 1'b1;
    end

    // Entry 0 is always the head; entry 1 shifts down on pop.
    case (cnt_q)
      2'd0: begin
        if (accept) begin
          data0_d = word;
          last0_d = word_last;
          cnt_d   = 2'd1;
        end
      end
      2'd1: begin
        if (pop && accept) begin
          data0_d = word;
          last0_d = word_last;
        end else if (pop) begin
          cnt_d = 2'd0;
        end else if (accept) begin
          data1_d = word;
          last1_d = word_last;
          cnt_d   = 2'd2;
        end
      end
      default: begin
        if (pop) begin
          data0_d = data1_q;
          last0_d = last1_q;
          if (accept) begin
            data1_d = word;
            last1_d = word_last;
          end else begin
            cnt_d = 2'd1;
          end
        end
      end
    endcase

    // Set beats clear when a drop and a clear land on the same edge.
    if (drop)              ovf_d = 1'b1;
    else if (overflow_clr) ovf_d = 1'b0;
    else                   ovf_d = ovf_q;
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      sync_q    <= '0;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      frame_q   <= '0;
      data0_q   <= '0;
      data1_q   <= '0;
      last0_q   <= 1'b0;
      last1_q   <= 1'b0;
      cnt_q     <= 2'd0;
      ovf_q     <= 1'b0;
    end else begin
      sync_q    <= sync_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      frame_q   <= frame_d;
      data0_q   <= data0_d;
      data1_q   <= data1_d;
      last0_q   <= last0_d;
      last1_q   <= last1_d;
      cnt_q     <= cnt_d;
      ovf_q     <= ovf_d;
    end
  end

  assign m_axis_tdata  = data0_q;
  assign m_axis_tlast  = last0_q;
  assign m_axis_tvalid = (cnt_q != 2'd0);
  assign overflow      = ovf_q;

endmodule

// File: tb/tb_pdm_deserializer.sv
// Bench for pdm_deserializer: random and patterned PDM streams checked each
// cycle against a queue-based model of words, frames and the 2-deep buffer.
module tb_pdm_deserializer;
  localparam int WORD_W      = 16;
  localparam int FRAME_WORDS = 4;
  localparam int PER         = 12;   // clk per mic-clock pulse

  logic clk = 1'b0, rst = 1'b0, en = 1'b0, m_clk_rising = 1'b0, pdm_data = 1'b0;
  logic m_axis_tready = 1'b0, overflow_clr = 1'b0;
  logic [WORD_W-1:0] m_axis_tdata;
  logic m_axis_tvalid, m_axis_tlast, overflow;

  always #5 clk = ~clk;

  pdm_deserializer #(.WORD_W(WORD_W), .FRAME_WORDS(FRAME_WORDS)) dut (
    .clk(clk), .rst(rst), .en(en), .m_clk_rising(m_clk_rising), .pdm_data(pdm_data),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tlast(m_axis_tlast), .overflow(overflow), .overflow_clr(overflow_clr)
  );

  typedef struct { logic [WORD_W-1:0] d; logic l; } word_t;

  // reference model state
  word_t expq[$];
  bit    bq[$];
  int    frame_m = 0;
  bit    ovf_m = 0, fresh_m = 1;
  logic [WORD_W-1:0] pats[$];
  int    pidx = 0;

  // stimulus knobs
  int ph = 0, rst_lo = 5, en_lo = 0;
  bit en_lvl = 0, en_at7 = 0, rst_at7 = 0;
  int d_mode = 0, r_mode = 0, clr_pct = 0, en_pct = 0, rst_pct = 0;

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
  endtask

  // Apply the effect of the upcoming clk edge to the model.
  task automatic model_edge();
    bit pop, push, drop;
    word_t w;
    w.d = '0; w.l = 1'b0;
    if (!rst) begin
      expq.delete(); bq.delete(); frame_m = 0; ovf_m = 0; fresh_m = 1;
      return;
    end
    pop = m_axis_tready && (expq.size() != 0);
    push = 0; drop = 0;
    if (!en) begin
      bq.delete(); frame_m = 0;
    end else if (m_clk_rising) begin
      bq.push_back(pdm_data);
      if (bq.size() == WORD_W) begin
        foreach (bq[i]) w.d = (w.d << 1) | WORD_W'(bq[i]);
        bq.delete();
        pidx++;
        if (expq.size() == 2 && !pop) drop = 1;
        else begin
          push = 1;
          w.l = (frame_m == FRAME_WORDS - 1);
          frame_m = (frame_m + 1) % FRAME_WORDS;
        end
      end
    end
    if (pop) void'(expq.pop_front());
    if (push) begin expq.push_back(w); fresh_m = 0; end
    if (overflow_clr) ovf_m = 0;
    if (drop) ovf_m = 1;
  endtask

  // One clk: check outputs, choose inputs for the next edge, advance model.
  task automatic step();
    logic [WORD_W-1:0] pw;
    @(negedge clk);
    chk("tvalid", m_axis_tvalid, expq.size() != 0);
    chk("overflow", overflow, ovf_m);
    if (expq.size() != 0) begin
      chk("tdata", m_axis_tdata, expq[0].d);
      chk("tlast", m_axis_tlast, expq[0].l);
    end else if (fresh_m) begin
      chk("tdata_rst", m_axis_tdata, 0);
      chk("tlast_rst", m_axis_tlast, 0);
    end

    ph = (ph + 1) % PER;
    m_clk_rising = (ph == 0);

    if (rst_lo == 0 && ph == 3 &&
        ((rst_at7 && bq.size() == 7) || (rst_pct != 0 && $urandom_range(99) < rst_pct))) begin
      rst_at7 = 0; rst_lo = 3;
    end
    rst = (rst_lo == 0);
    if (rst_lo != 0) rst_lo--;

    if (en_lo == 0 && ph == 5 &&
        ((en_at7 && bq.size() == 7) || (en_pct != 0 && $urandom_range(99) < en_pct))) begin
      en_at7 = 0; en_lo = PER;
    end
    en = en_lvl && (en_lo == 0);
    if (en_lo != 0) en_lo--;

    // data only changes right after a pulse, so it is long stable at the next one
    if (ph == 1) begin
      case (d_mode)
        1: pdm_data = (bq.size() % 2 == 0);
        2: pdm_data = 1'b1;
        3: begin pw = pats[pidx % pats.size()]; pdm_data = pw[WORD_W-1-bq.size()]; end
        default: pdm_data = 1'($urandom_range(1));
      endcase
    end

    case (r_mode)
      1: m_axis_tready = 1'b1;
      2: m_axis_tready = ($urandom_range(3) == 0);
      3: m_axis_tready = (expq.size() == 2) && m_clk_rising && en && (bq.size() == WORD_W - 1);
      default: m_axis_tready = 1'b0;
    endcase

    overflow_clr = (clr_pct != 0) && ($urandom_range(99) < clr_pct);
    model_edge();
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic idle();
    en_lvl = 0; run(2 * PER); en_lvl = 1;
  endtask

  localparam int WCYC = WORD_W * PER;

  initial begin
    // reset, then idle with pulses
    run(8);
    en_lvl = 0; r_mode = 1; run(10 * PER);

    // 1010... packing, immediate drain
    en_lvl = 1; d_mode = 1; run(4 * WCYC + PER);

    // constant ones, frame marking on every 4th word
    idle(); d_mode = 2; run(12 * WCYC + PER);

    // back-pressure: third word dropped, then drain, then clear
    idle(); r_mode = 0; d_mode = 3; pats = '{16'h1234, 16'h5678, 16'h9ABC}; pidx = 0;
    run(3 * WCYC + PER);
    en_lvl = 0; r_mode = 1; run(4 * PER);
    clr_pct = 100; run(1); clr_pct = 0; run(4);

    // simultaneous push and pop while full
    idle(); r_mode = 0; d_mode = 0;
    for (int i = 0; i < 4 * WCYC && expq.size() != 2; i++) step();
    r_mode = 3; run(WCYC + PER);
    r_mode = 1; run(4 * PER);

    // enable dropped after 7 samples, then 0x00FF words with a fresh frame
    idle(); d_mode = 3; pats = '{16'h00FF}; pidx = 0; en_at7 = 1;
    run(7 * WCYC);

    // reset mid-word with a word buffered
    idle(); r_mode = 0; d_mode = 0;
    for (int i = 0; i < 3 * WCYC && expq.size() != 1; i++) step();
    rst_at7 = 1; run(2 * WCYC);
    r_mode = 1; run(2 * WCYC);

    // random soak
    r_mode = 2; clr_pct = 2; en_pct = 3; rst_pct = 1;
    run(15000);
    r_mode = 1; en_pct = 0; rst_pct = 0; clr_pct = 0; run(3 * WCYC);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
